// File: rtl/muldiv_hazard_unit.sv
// Hazard detection for load-use and multi-cycle RV32M occupancy; drives stall_pipeline.
// Optional macro DIV_EARLY_OUT_EN: divide by zero completes after a single stall cycle.
module muldiv_hazard_unit #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_muldiv_valid,
    input  logic [2:0] ex_muldiv_funct3,
    input  logic       ex_div_by_zero,
    output logic       stall_pipeline,
    output logic       load_use_hazard,
    output logic       mdu_busy,
    output logic       mdu_done,
    output logic [4:0] mdu_rd
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY     = 2'd1,
        COMPLETE = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] counter, counter_next;
    logic       busy_next, done_next;
    logic [4:0] rd_next;
    logic       start;
    logic       early_out;
    logic [7:0] n_cycles;
    logic       unused_inputs;

`ifdef DIV_EARLY_OUT_EN
    always_comb begin
        early_out     = ex_muldiv_funct3[2] & ex_div_by_zero;
        unused_inputs = ^ex_muldiv_funct3[1:0];
    end
`else
    always_comb begin
        early_out     = 1'b0;
        unused_inputs = ^{ex_muldiv_funct3[1:0], ex_div_by_zero};
    end
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state    <= IDLE;
            counter  <= '0;
            mdu_busy <= 1'b0;
            mdu_done <= 1'b0;
            mdu_rd   <= '0;
        end else begin
            state    <= state_next;
            counter  <= counter_next;
            mdu_busy <= busy_next;
            mdu_done <= done_next;
            mdu_rd   <= rd_next;
        end
    end

    // Busy/done are registered copies of the next state, so they track BUSY/COMPLETE exactly.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        busy_next    = mdu_busy;
        done_next    = 1'b0;
        rd_next      = mdu_rd;
        n_cycles     = ex_muldiv_funct3[2] ? DIV_CYCLES[7:0] : MUL_CYCLES[7:0];
        unique case (state)
            IDLE: begin
                if (start) begin
                    rd_next = ex_rd;
                    if ((n_cycles == 8'd1) || early_out) begin
                        state_next = COMPLETE;
                        done_next  = 1'b1;
                    end else begin
                        counter_next = n_cycles - 8'd1;
                        busy_next    = 1'b1;
                        state_next   = BUSY;
                    end
                end
            end
            BUSY: begin
                counter_next = counter - 8'd1;
                if (counter == 8'd1) begin
                    state_next = COMPLETE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end
            end
            COMPLETE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        start           = (state == IDLE) & ex_muldiv_valid;
        load_use_hazard = ex_mem_read & (ex_rd != 5'd0) &
                          ((id_rs1_used & (id_rs1 == ex_rd)) |
                           (id_rs2_used & (id_rs2 == ex_rd)));
        stall_pipeline  = start | (state == BUSY) | (load_use_hazard & (state == IDLE));
    end

endmodule

// File: doc/muldiv_hazard_unit.md
Name: muldiv_hazard_unit

Overview:
Hazard detection stage directly upstream of the pipeline hazard control logic; it generates the stall_pipeline request that freezes the PC and IF/ID and inserts an EX bubble.
- Covers two stall sources:
  - Classic load-use hazard between the ID and EX stages.
  - Multi-cycle RV32M occupancy: MUL* ops take MUL_CYCLES cycles and DIV/REM ops take DIV_CYCLES cycles.
- Holds a small FSM plus cycle counter tracking the in-flight M-extension op, and reports its completion and destination register to writeback.

Parameters:
MUL_CYCLES, 2, total stall cycles for funct3 000-011 (legal range 1..255)
DIV_CYCLES, 32, total stall cycles for funct3 100-111 (legal range 1..255)

Ports:
CLK  input  1  system clock, rising edge
RESETn  input  1  asynchronous active-low reset
id_rs1  input  5  rs1 of instruction in ID
id_rs2  input  5  rs2 of instruction in ID
id_rs1_used  input  1  ID instruction reads rs1
id_rs2_used  input  1  ID instruction reads rs2
ex_rd  input  5  rd of instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_muldiv_valid  input  1  valid M-extension op present in EX this cycle
ex_muldiv_funct3  input  3  funct3 of that op
ex_div_by_zero  input  1  divisor operand is zero (used only with optional feature)
stall_pipeline  output  1  combinational stall request to the hazard control logic
load_use_hazard  output  1  combinational; load-use term only
mdu_busy  output  1  registered; M op in flight
mdu_done  output  1  registered; one-cycle completion pulse
mdu_rd  output  5  registered; rd of in-flight/completing op

Behaviour:
- Reset (RESETn low, async): state=IDLE, counter=0, mdu_busy=0, mdu_done=0, mdu_rd=0. Reset mid-operation abandons the op; no mdu_done pulse is produced.
- load_use_hazard = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- start = (state==IDLE) & ex_muldiv_valid.
- N = DIV_CYCLES if funct3[2], else MUL_CYCLES.
- States:
  - IDLE: on start, latch mdu_rd<=ex_rd.
    - If N==1: go to COMPLETE.
    - Otherwise: counter<=N-1, mdu_busy<=1, go to BUSY.
    - ex_muldiv_valid is ignored outside IDLE: the EX slot holds a bubble while stalled.
  - BUSY: counter decrements each cycle. When counter==1, go to COMPLETE and clear mdu_busy.
  - COMPLETE: mdu_done=1 for exactly one cycle, then IDLE; mdu_rd holds its value until the next start.
- stall_pipeline = start | (state==BUSY) | (load_use_hazard & state==IDLE).
  - Stall is asserted in the start cycle and every BUSY cycle: exactly N stall cycles per op.
  - Stall is low in the COMPLETE cycle.
- Load-use during BUSY is masked; stall is already high, and the term re-evaluates after release.
- start and load_use in the same cycle: the stall is a single OR. The FSM still starts, and the load-use condition is re-evaluated once the op completes.
- Back-to-back M ops: the second can start in the cycle after COMPLETE at the earliest, because the COMPLETE state is not IDLE.
- Counter width is 8 bits. There is no wrap-around, because the counter is loaded only with N-1 ≤ 254.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: a start with funct3[2]=1 and ex_div_by_zero=1 goes straight to COMPLETE. Result is 1 stall cycle and mdu_done in the next cycle, mdu_busy never set.
- When undefined: ex_div_by_zero is ignored, and every divide takes DIV_CYCLES.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> load_use_hazard=1 and stall_pipeline=1. Repeat with ex_rd=0 -> both 0.
- MUL: ex_muldiv_valid=1 for one cycle, funct3=000, ex_rd=7 -> stall high for exactly 2 cycles; mdu_done pulses 1 cycle with mdu_rd=7; mdu_busy high for 1 cycle.
- DIV: funct3=100, ex_rd=9 -> stall high for exactly 32 consecutive cycles; mdu_done pulses on cycle 33; mdu_busy high for cycles 2-32.
- Masking: during a DIV BUSY, assert a load-use match and pulse ex_muldiv_valid -> no second start; stall and timing unchanged.
- Reset mid-DIV: drop RESETn at BUSY cycle 10 -> all outputs 0 immediately; no mdu_done; a new MUL after release completes in 2 cycles.
- DIV_EARLY_OUT_EN: DIV with ex_div_by_zero=1 -> 1 stall cycle and mdu_done next cycle. With the macro undefined -> 32 cycles.
